// File: rtl/pp_pkg.sv
// pp_pkg: shared rdy/ack pipeline constants, default widths and clog2 helper.
package pp_pkg;
  localparam logic PP_IDLE  = 1'b0;
  localparam logic PP_VALID = 1'b1;
  localparam int   PP_BW    = 8;
  localparam int   PP_DEPTH = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/pp_fifo_ptr.sv
// pp_fifo_ptr: wrapping pointer with increment enable; wraps modulo 2**AW.
module pp_fifo_ptr #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [AW-1:0] ptr
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (en) ptr <= ptr + 1'b1;
endmodule

// File: rtl/pp_fifo.sv
// pp_fifo: rdy/ack FIFO, responder upstream and initiator downstream.
// Define PP_FIFO_SIMUL_EN to accept a push into a full FIFO while its head pops.
module pp_fifo
  import pp_pkg::*;
#(
  parameter int BW    = PP_BW,
  parameter int DEPTH = PP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rdy,
  output logic                  i_ack,
  input  logic [BW-1:0]         i_dat,
  output logic                  o_rdy,
  input  logic                  o_ack,
  output logic [BW-1:0]         o_dat,
  output logic [clog2(DEPTH):0] level
);
  localparam int AW = clog2(DEPTH);
  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
`ifdef PP_FIFO_SIMUL_EN
  assign i_ack = i_rdy & (~full | o_ack);
`else
  assign i_ack = i_rdy & ~full;
`endif
  assign push  = i_rdy & i_ack;
  assign pop   = o_rdy & o_ack;
  assign o_rdy = empty ? PP_IDLE : PP_VALID;
  assign o_dat = mem[rptr];
  assign level = count;
  pp_fifo_ptr #(.AW(AW)) u_wptr (.clk, .rst_n, .en(push), .ptr(wptr));
  pp_fifo_ptr #(.AW(AW)) u_rptr (.clk, .rst_n, .en(pop),  .ptr(rptr));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= count + (AW+1)'(push) - (AW+1)'(pop);
  // when full with simultaneous push, wptr==rptr: the write replaces the retiring head
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (push) mem[wptr] <= i_dat;
endmodule
